// File: rtl/reg_rename_file_pkg.sv
// Shared widths and constants for the architectural register file with rename tags.
package reg_rename_file_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_IDX_W = 4;
  localparam int NREG      = 32;
  localparam int RIDX_W    = 5;

  localparam logic [RIDX_W-1:0] X0_IDX = 5'd0;
  localparam logic              TRUE   = 1'b1;
  localparam logic              FALSE  = 1'b0;

  typedef logic [XLEN-1:0]      xdata_t;
  typedef logic [ROB_IDX_W-1:0] rbid_t;
  typedef logic [RIDX_W-1:0]    ridx_t;

  // Packs a ROB tag into the data lane of a not-ready operand.
  function automatic xdata_t tag_to_val(input rbid_t tag);
    return {{(XLEN-ROB_IDX_W){1'b0}}, tag};
  endfunction

endpackage

// File: rtl/reg_rename_file_read_port.sv
// One operand lookup: x0 constant, committed value, commit bypass or pending ROB tag.
module reg_read_port
  import reg_rename_file_pkg::*;
(
  input  logic              rst,
  input  logic [RIDX_W-1:0] addr,
  input  logic              busy,
  input  logic [ROB_IDX_W-1:0] tag,
  input  logic [XLEN-1:0]   reg_val,
  input  logic              cm_en,
  input  logic [RIDX_W-1:0] cm_rd,
  input  logic [ROB_IDX_W-1:0] cm_tag,
  input  logic [XLEN-1:0]   cm_val,
  output logic              ready,
  output logic [XLEN-1:0]   val
);

  // Priority: reset blanking, x0, idle register, retiring producer, pending tag.
  always_comb begin
    ready = FALSE;
    val   = '0;
    if (rst) begin
      ready = FALSE;
      val   = '0;
    end else if (addr == X0_IDX) begin
      ready = TRUE;
      val   = '0;
    end else if (!busy) begin
      ready = TRUE;
      val   = reg_val;
    end else if (cm_en && (cm_rd == addr) && (cm_tag == tag)) begin
      ready = TRUE;
      val   = cm_val;
    end else begin
      ready = FALSE;
      val   = tag_to_val(tag);
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file plus per-register busy/ROB-tag, updated by rename and commit.
module reg_rename_file
  import reg_rename_file_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 rn_en,
  input  logic [RIDX_W-1:0]    rn_rd,
  input  logic [ROB_IDX_W-1:0] rn_tag,
  input  logic                 cm_en,
  input  logic [RIDX_W-1:0]    cm_rd,
  input  logic [ROB_IDX_W-1:0] cm_tag,
  input  logic [XLEN-1:0]      cm_val,
  input  logic [RIDX_W-1:0]    rs1_addr,
  input  logic [RIDX_W-1:0]    rs2_addr,
  output logic                 rs1_ready,
  output logic [XLEN-1:0]      rs1_val,
  output logic                 rs2_ready,
  output logic [XLEN-1:0]      rs2_val
);

  logic [XLEN-1:0]      regs_q [NREG];
  logic [XLEN-1:0]      regs_d [NREG];
  logic                 busy_q [NREG];
  logic                 busy_d [NREG];
  logic [ROB_IDX_W-1:0] tag_q  [NREG];
  logic [ROB_IDX_W-1:0] tag_d  [NREG];

  // Commit first, then rename overrides its busy clear; flush clears everything last.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      busy_d[i] = busy_q[i];
      tag_d[i]  = tag_q[i];
    end
    if (rdy) begin
      if (cm_en && (cm_rd != X0_IDX)) begin
        regs_d[cm_rd] = cm_val;
        if (busy_q[cm_rd] && (tag_q[cm_rd] == cm_tag)) begin
          busy_d[cm_rd] = FALSE;
        end else begin
          busy_d[cm_rd] = busy_q[cm_rd];
        end
      end else begin
        regs_d[X0_IDX] = '0;
      end
      if (flush) begin
        for (int i = 0; i < NREG; i++) begin
          busy_d[i] = FALSE;
        end
      end else if (rn_en && (rn_rd != X0_IDX)) begin
        busy_d[rn_rd] = TRUE;
        tag_d[rn_rd]  = rn_tag;
      end else begin
        busy_d[X0_IDX] = FALSE;
      end
    end else begin
      regs_d[X0_IDX] = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        busy_q[i] <= FALSE;
        tag_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
        busy_q[i] <= busy_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

  reg_read_port u_rs1 (
    .rst     (rst),
    .addr    (rs1_addr),
    .busy    (busy_q[rs1_addr]),
    .tag     (tag_q[rs1_addr]),
    .reg_val (regs_q[rs1_addr]),
    .cm_en   (cm_en),
    .cm_rd   (cm_rd),
    .cm_tag  (cm_tag),
    .cm_val  (cm_val),
    .ready   (rs1_ready),
    .val     (rs1_val)
  );

  reg_read_port u_rs2 (
    .rst     (rst),
    .addr    (rs2_addr),
    .busy    (busy_q[rs2_addr]),
    .tag     (tag_q[rs2_addr]),
    .reg_val (regs_q[rs2_addr]),
    .cm_en   (cm_en),
    .cm_rd   (cm_rd),
    .cm_tag  (cm_tag),
    .cm_val  (cm_val),
    .ready   (rs2_ready),
    .val     (rs2_val)
  );

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file: rename, commit, bypass, flush, stall and x0 cases.
module tb_reg_rename_file;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        rn_en, cm_en;
  logic [4:0]  rn_rd, cm_rd, rs1_addr, rs2_addr;
  logic [3:0]  rn_tag, cm_tag;
  logic [31:0] cm_val;
  logic        rs1_ready, rs2_ready;
  logic [31:0] rs1_val, rs2_val;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  reg_rename_file dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .rn_en(rn_en), .rn_rd(rn_rd), .rn_tag(rn_tag),
    .cm_en(cm_en), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_val(cm_val),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_ready(rs1_ready), .rs1_val(rs1_val),
    .rs2_ready(rs2_ready), .rs2_val(rs2_val)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [4:0] a, input logic rdy_e, input logic [31:0] val_e);
    rs1_addr = a;
    #1;
    n_checks++;
    assert ({rs1_ready, rs1_val} === {rdy_e, val_e})
    else begin
      n_fails++;
      $error("FAIL %s rs1: observed ready=%b val=%h expected ready=%b val=%h",
             tag, rs1_ready, rs1_val, rdy_e, val_e);
    end
  endtask

  task automatic chk2(input string tag, input logic [4:0] a, input logic rdy_e, input logic [31:0] val_e);
    rs2_addr = a;
    #1;
    n_checks++;
    assert ({rs2_ready, rs2_val} === {rdy_e, val_e})
    else begin
      n_fails++;
      $error("FAIL %s rs2: observed ready=%b val=%h expected ready=%b val=%h",
             tag, rs2_ready, rs2_val, rdy_e, val_e);
    end
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] t);
    rn_en = 1'b1; rn_rd = rd; rn_tag = t;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] t, input logic [31:0] v);
    cm_en = 1'b1; cm_rd = rd; cm_tag = t; cm_val = v;
  endtask

  task automatic idle();
    rn_en = 1'b0; cm_en = 1'b0; flush = 1'b0; rdy = 1'b1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    rn_en = 1'b0; rn_rd = 5'd0; rn_tag = 4'd0;
    cm_en = 1'b0; cm_rd = 5'd0; cm_tag = 4'd0; cm_val = 32'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;

    tick();
    chk1("in_reset_rs1", 5'd5, 1'b0, 32'h0);
    chk2("in_reset_rs2", 5'd0, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    chk1("post_reset_x5", 5'd5, 1'b1, 32'h0);
    chk2("post_reset_x0", 5'd0, 1'b1, 32'h0);
    chk2("post_reset_x5_rs2", 5'd5, 1'b1, 32'h0);

    // Rename, bypass on commit, then settled value.
    rename(5'd3, 4'd7); tick(); idle();
    chk1("x3_busy_tag7", 5'd3, 1'b0, 32'h7);
    commit(5'd3, 4'd7, 32'hDEAD);
    chk1("x3_bypass", 5'd3, 1'b1, 32'hDEAD);
    chk2("x3_bypass_rs2", 5'd3, 1'b1, 32'hDEAD);
    tick(); idle();
    chk1("x3_committed", 5'd3, 1'b1, 32'hDEAD);

    // Stale commit leaves the newer rename pending.
    rename(5'd4, 4'd2); tick();
    rename(5'd4, 4'd9); tick(); idle();
    commit(5'd4, 4'd2, 32'd5);
    chk2("x4_stale_no_bypass", 5'd4, 1'b0, 32'h9);
    tick(); idle();
    chk2("x4_after_stale", 5'd4, 1'b0, 32'h9);
    commit(5'd4, 4'd9, 32'd6);
    chk2("x4_bypass_tag9", 5'd4, 1'b1, 32'd6);
    tick(); idle();
    chk2("x4_committed", 5'd4, 1'b1, 32'd6);

    // Same-cycle rename + matching commit: rename wins, value still written.
    rename(5'd6, 4'd12); tick(); idle();
    rename(5'd6, 4'd1); commit(5'd6, 4'd12, 32'h11);
    chk1("x6_bypass_before_edge", 5'd6, 1'b1, 32'h11);
    tick(); idle();
    chk1("x6_rename_wins", 5'd6, 1'b0, 32'h1);
    commit(5'd6, 4'd1, 32'h22); tick(); idle();
    chk1("x6_final", 5'd6, 1'b1, 32'h22);

    // Flush with simultaneous rename and commit.
    rename(5'd7, 4'd3); tick();
    rename(5'd8, 4'd4); tick(); idle();
    chk1("x7_busy", 5'd7, 1'b0, 32'h3);
    chk2("x8_busy", 5'd8, 1'b0, 32'h4);
    flush = 1'b1; rename(5'd9, 4'd5); commit(5'd10, 4'd0, 32'h77);
    tick(); idle();
    chk1("x7_flushed", 5'd7, 1'b1, 32'h0);
    chk2("x8_flushed", 5'd8, 1'b1, 32'h0);
    chk1("x9_rename_dropped", 5'd9, 1'b1, 32'h0);
    chk2("x10_commit_in_flush", 5'd10, 1'b1, 32'h77);

    // Stall: no state change; read still combinational.
    rename(5'd11, 4'd6); tick(); idle();
    rdy = 1'b0;
    rename(5'd12, 4'd2); commit(5'd10, 4'd1, 32'h99);
    tick();
    commit(5'd11, 4'd6, 32'h55);
    chk1("stall_bypass_comb", 5'd11, 1'b1, 32'h55);
    tick(); idle();
    chk1("stall_x11_still_busy", 5'd11, 1'b0, 32'h6);
    chk2("stall_x12_not_renamed", 5'd12, 1'b1, 32'h0);
    chk2("stall_x10_unchanged", 5'd10, 1'b1, 32'h77);

    // x0 ignores rename and commit.
    rename(5'd0, 4'd3); tick(); idle();
    chk1("x0_rename_ignored", 5'd0, 1'b1, 32'h0);
    commit(5'd0, 4'd3, 32'hFF); tick(); idle();
    chk2("x0_commit_ignored", 5'd0, 1'b1, 32'h0);

    // Mid-run reset clears values and busy.
    rst = 1'b1;
    chk1("rst_blanks_read", 5'd3, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    chk1("rst_clears_x3", 5'd3, 1'b1, 32'h0);
    chk2("rst_clears_x11", 5'd11, 1'b1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
